// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision definitions for the real_mul datapath.
package fp32_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;
  localparam logic [EXP_W-1:0] EXP_MAX    = 8'hFF;
  localparam logic [31:0]      QNAN_CANON = 32'h7FC0_0000;

  // Bit positions within the 4-bit {invalid, overflow, underflow, inexact} flag word
  localparam int FLG_INVALID   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/operand_analyzer.sv
// Combinational classifier for one IEEE-754 single operand; denormals report as zero.
module operand_analyzer
  import fp32_pkg::*;
(
  input  logic [31:0]       op_i,
  output logic              sign_o,
  output logic [EXP_W-1:0]  exp_o,
  output logic [FRAC_W:0]   mant_o,
  output logic              is_zero_o,
  output logic              is_inf_o,
  output logic              is_nan_o,
  output logic              is_snan_o
);
  logic [FRAC_W-1:0] frac;

  assign sign_o    = op_i[31];
  assign exp_o     = op_i[30:23];
  assign frac      = op_i[22:0];
  assign mant_o    = {1'b1, frac};
  assign is_zero_o = (exp_o == '0);
  assign is_inf_o  = (exp_o == EXP_MAX) && (frac == '0);
  assign is_nan_o  = (exp_o == EXP_MAX) && (frac != '0);
  assign is_snan_o = is_nan_o && !frac[FRAC_W-1];
endmodule

// File: rtl/fp32_mul_seq.sv
// Sequential fp32 multiplier: special cases resolve at accept, normal operands go
// through an iterative shift-add mantissa multiply, then normalise/round/pack.
module fp32_mul_seq
  import fp32_pkg::*;
#(
  parameter int          BITS_PER_CYCLE = 1,
  parameter logic [31:0] QNAN_CANON     = fp32_pkg::QNAN_CANON
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  flags,
  output logic        busy
);
  localparam int         CYCLES   = 24 / BITS_PER_CYCLE;
  localparam logic [4:0] CNT_LAST = 5'(CYCLES - 1);

  logic               sa, sb, za, zb, ia, ib, na, nb, sna, snb;
  logic [EXP_W-1:0]   ea, eb;
  logic [FRAC_W:0]    ma, mb;

  operand_analyzer u_ana_a (.op_i(a), .sign_o(sa), .exp_o(ea), .mant_o(ma),
    .is_zero_o(za), .is_inf_o(ia), .is_nan_o(na), .is_snan_o(sna));
  operand_analyzer u_ana_b (.op_i(b), .sign_o(sb), .exp_o(eb), .mant_o(mb),
    .is_zero_o(zb), .is_inf_o(ib), .is_nan_o(nb), .is_snan_o(snb));

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [47:0]        acc_q, acc_d, mcand_q, mcand_d;
  logic [23:0]        mplier_q, mplier_d;
  logic signed [9:0]  exp_q, exp_d;
  logic               sign_q, sign_d;
  logic [31:0]        result_q, result_d;
  logic [3:0]         flags_q, flags_d;
  logic [35:0]        packed_norm;
  logic               special, sign_in;

  // Normalise, round-to-nearest-even and range check; returns {flags, result}.
  function automatic logic [35:0] norm_round(input logic [47:0] p,
                                             input logic signed [9:0] e_in,
                                             input logic s);
    logic [22:0]       mant;
    logic              g, st, inc, carry;
    logic signed [9:0] e;
    logic [3:0]        f;
    logic [31:0]       r;
    e = e_in;
    if (p[47]) begin
      mant = p[46:24]; g = p[23]; st = |p[22:0]; e = e + 10'sd1;
    end else begin
      mant = p[45:23]; g = p[22]; st = |p[21:0];
    end
    inc = g && (st || mant[0]);
    {carry, mant} = {1'b0, mant} + {23'd0, inc};
    if (carry) e = e + 10'sd1;
    f = '0;
    f[FLG_INEXACT] = g | st;
    if (e >= 10'sd255) begin
      r = {s, EXP_MAX, 23'd0};
      f[FLG_OVERFLOW] = 1'b1; f[FLG_INEXACT] = 1'b1;
    end else if (e <= 10'sd0) begin
      r = {s, 31'd0};
      f[FLG_UNDERFLOW] = 1'b1; f[FLG_INEXACT] = 1'b1;
    end else begin
      r = {s, e[7:0], mant};
    end
    return {f, r};
  endfunction

  assign special     = na | nb | ia | ib | za | zb;
  assign sign_in     = sa ^ sb;
  assign packed_norm = norm_round(acc_q, exp_q, sign_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    result_d = result_q;
    flags_d  = flags_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        sign_d   = sign_in;
        exp_d    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        acc_d    = '0;
        mcand_d  = {24'd0, ma};
        mplier_d = mb;
        cnt_d    = '0;
        if (special) begin
          flags_d = '0;
          if (na || nb) begin
            result_d = QNAN_CANON;
            flags_d[FLG_INVALID] = sna | snb;
          end else if ((ia && zb) || (za && ib)) begin
            result_d = QNAN_CANON;
            flags_d[FLG_INVALID] = 1'b1;
          end else if (ia || ib) begin
            result_d = {sign_in, EXP_MAX, 23'd0};
          end else begin
            result_d = {sign_in, 31'd0};
          end
          state_d = DONE;
        end else begin
          state_d = MUL;
        end
      end
      MUL: begin
        for (int i = 0; i < BITS_PER_CYCLE; i++)
          if (mplier_q[i]) acc_d = acc_d + (mcand_q << i);
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = NORM;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      NORM: begin
        flags_d  = packed_norm[35:32];
        result_d = packed_norm[31:0];
        state_d  = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign flags     = flags_q;
endmodule

// File: tb/tb_fp32_mul_seq.sv
// Directed-vector bench for fp32_mul_seq: table of products plus backpressure and reset sequences.
module tb_fp32_mul_seq;
  localparam int BPC     = 1;
  localparam int LAT_NRM = 24 / BPC + 2;
  localparam int LAT_SPC = 1;
  localparam int LIMIT   = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0, b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fp32_mul_seq #(.BITS_PER_CYCLE(BPC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one operand pair, counts clock edges from the accept edge to out_valid.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_);
    @(posedge clk); #1;
    a = ta; b = tb_; in_valid = 1'b1;
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] held;

    vecs[0]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, LAT_NRM};
    vecs[1]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, LAT_NRM};
    vecs[2]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000, LAT_NRM};
    vecs[3]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, LAT_SPC};
    vecs[4]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, LAT_SPC};
    vecs[5]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101, LAT_NRM};
    vecs[6]  = '{32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, LAT_NRM};
    vecs[7]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, LAT_NRM};
    vecs[8]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, LAT_SPC};
    vecs[9]  = '{32'h00400000, 32'h40000000, 32'h00000000, 4'b0000, LAT_SPC};
    vecs[10] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, LAT_SPC};
    vecs[11] = '{32'h7FC00000, 32'hBF800000, 32'h7FC00000, 4'b0000, LAT_SPC};

    #12;
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_result",    result,             32'd0);
    check("rst_flags",     {28'd0, flags},     32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done(lat);
      check($sformatf("v%0d_result", i), result, vecs[i].res);
      check($sformatf("v%0d_flags", i), {28'd0, flags}, {28'd0, vecs[i].flg});
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      pop();
      check($sformatf("v%0d_idle_after_pop", i), {31'd0, in_ready}, 32'd1);
    end

    // Backpressure: result held, new requests ignored while DONE waits
    start_op(32'h3FC00000, 32'h40000000);
    wait_done(lat);
    held = result;
    check("bp_result_first", result, 32'h40400000);
    a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_result_stable", result, held);
      check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid_high", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    pop();
    check("bp_busy_after_pop", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of the multiply
    start_op(32'h3FC00000, 32'h40000000);
    repeat (5) @(posedge clk);
    #2;
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("mid_rst_busy",      {31'd0, busy},      32'd0);
    check("mid_rst_result",    result,             32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_op(32'hC0000000, 32'h40400000);
    wait_done(lat);
    check("post_rst_result",  result, 32'hC0C00000);
    check("post_rst_latency", lat, LAT_NRM);
    pop();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
